// File: rtl/caf_pkg.sv
// Shared types and elaboration helpers for the CAF peak-detect reduction stage.
package caf_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    OUT   = 2'd2
  } state_t;

  // DRAIN holds until the last sample has passed the compare stage.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  function automatic int mag_bits(input int wi, input int wq);
    return 2 * ((wi > wq) ? wi : wq) + 1;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/caf_peak_detect_cmag_sq.sv
// Two-stage registered |p|^2 = i^2 + q^2 with valid tag and (i, q, idx) sideband.
module cmag_sq
  import caf_pkg::*;
#(
  parameter int WI   = 16,
  parameter int WQ   = 16,
  parameter int IDXW = 6,
  parameter int MAGW = mag_bits(WI, WQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic signed [WI-1:0]   in_i,
  input  logic signed [WQ-1:0]   in_q,
  input  logic [IDXW-1:0]        in_idx,
  output logic                   out_valid,
  output logic [MAGW-1:0]        out_mag,
  output logic signed [WI-1:0]   out_i,
  output logic signed [WQ-1:0]   out_q,
  output logic [IDXW-1:0]        out_idx
);

  logic                   s1_valid_q, s1_valid_d;
  logic signed [2*WI-1:0] sq_i_q, sq_i_d;
  logic signed [2*WQ-1:0] sq_q_q, sq_q_d;
  logic signed [WI-1:0]   s1_i_q, s1_i_d;
  logic signed [WQ-1:0]   s1_q_q, s1_q_d;
  logic [IDXW-1:0]        s1_idx_q, s1_idx_d;

  logic                   s2_valid_q, s2_valid_d;
  logic [MAGW-1:0]        s2_mag_q, s2_mag_d;
  logic signed [WI-1:0]   s2_i_q, s2_i_d;
  logic signed [WQ-1:0]   s2_q_q, s2_q_d;
  logic [IDXW-1:0]        s2_idx_q, s2_idx_d;

  logic signed [2*WI-1:0] ext_i;
  logic signed [2*WQ-1:0] ext_q;

  // Full-width signed squares keep -2^(W-1) squared exact; data only moves with a valid sample.
  always_comb begin
    ext_i      = in_i;
    ext_q      = in_q;
    s1_valid_d = in_valid;
    sq_i_d     = sq_i_q;
    sq_q_d     = sq_q_q;
    s1_i_d     = s1_i_q;
    s1_q_d     = s1_q_q;
    s1_idx_d   = s1_idx_q;
    if (in_valid) begin
      sq_i_d   = ext_i * ext_i;
      sq_q_d   = ext_q * ext_q;
      s1_i_d   = in_i;
      s1_q_d   = in_q;
      s1_idx_d = in_idx;
    end

    s2_valid_d = s1_valid_q;
    s2_mag_d   = s2_mag_q;
    s2_i_d     = s2_i_q;
    s2_q_d     = s2_q_q;
    s2_idx_d   = s2_idx_q;
    if (s1_valid_q) begin
      s2_mag_d = {{(MAGW-2*WI){1'b0}}, sq_i_q} + {{(MAGW-2*WQ){1'b0}}, sq_q_q};
      s2_i_d   = s1_i_q;
      s2_q_d   = s1_q_q;
      s2_idx_d = s1_idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      sq_i_q     <= '0;
      sq_q_q     <= '0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_mag_q   <= '0;
      s2_i_q     <= '0;
      s2_q_q     <= '0;
      s2_idx_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      sq_i_q     <= sq_i_d;
      sq_q_q     <= sq_q_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_mag_q   <= s2_mag_d;
      s2_i_q     <= s2_i_d;
      s2_q_q     <= s2_q_d;
      s2_idx_q   <= s2_idx_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mag   = s2_mag_q;
  assign out_i     = s2_i_q;
  assign out_q     = s2_q_q;
  assign out_idx   = s2_idx_q;

endmodule

// File: rtl/caf_peak_detect.sv
// Frame-wise peak search of |p|^2 over LENGTH accepted complex products, result held until taken.
module caf_peak_detect
  import caf_pkg::*;
#(
  parameter int SUM_I_BITS = 16,
  parameter int SUM_Q_BITS = 16,
  parameter int LENGTH     = 64,
  parameter int INDEX_BITS = 6
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          s_axis_product_tvalid,
  output logic                                          m_axis_product_tready,
  input  logic signed [SUM_I_BITS-1:0]                  i,
  input  logic signed [SUM_Q_BITS-1:0]                  q,
  output logic                                          s_axis_peak_tvalid,
  input  logic                                          m_axis_peak_tready,
  output logic [mag_bits(SUM_I_BITS, SUM_Q_BITS)-1:0]   peak_mag,
  output logic [INDEX_BITS-1:0]                         peak_index,
  output logic signed [SUM_I_BITS-1:0]                  peak_i,
  output logic signed [SUM_Q_BITS-1:0]                  peak_q
);

  localparam int MAG_BITS = mag_bits(SUM_I_BITS, SUM_Q_BITS);

  if (LENGTH < 1 || clog2(LENGTH) > INDEX_BITS) begin : g_param_check
    $error("caf_peak_detect: LENGTH must be >= 1 and fit in INDEX_BITS");
  end

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   cnt_q, cnt_d;
  logic [1:0]              drain_cnt_q, drain_cnt_d;

  logic [MAG_BITS-1:0]     max_mag_q, max_mag_d;
  logic [INDEX_BITS-1:0]   max_idx_q, max_idx_d;
  logic signed [SUM_I_BITS-1:0] max_i_q, max_i_d;
  logic signed [SUM_Q_BITS-1:0] max_q_q, max_q_d;

  logic                    peak_valid_q, peak_valid_d;
  logic [MAG_BITS-1:0]     peak_mag_q, peak_mag_d;
  logic [INDEX_BITS-1:0]   peak_index_q, peak_index_d;
  logic signed [SUM_I_BITS-1:0] peak_i_q, peak_i_d;
  logic signed [SUM_Q_BITS-1:0] peak_q_q, peak_q_d;

  logic                    accept;
  logic                    mag_valid;
  logic [MAG_BITS-1:0]     mag;
  logic signed [SUM_I_BITS-1:0] mag_i;
  logic signed [SUM_Q_BITS-1:0] mag_q;
  logic [INDEX_BITS-1:0]   mag_idx;

  assign m_axis_product_tready = (state_q == ACCUM) & ~reset;
  assign accept                = s_axis_product_tvalid & m_axis_product_tready;

  cmag_sq #(
    .WI   (SUM_I_BITS),
    .WQ   (SUM_Q_BITS),
    .IDXW (INDEX_BITS),
    .MAGW (MAG_BITS)
  ) u_cmag_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_i      (i),
    .in_q      (q),
    .in_idx    (cnt_q),
    .out_valid (mag_valid),
    .out_mag   (mag),
    .out_i     (mag_i),
    .out_q     (mag_q),
    .out_idx   (mag_idx)
  );

  // Index 0 always loads so a new frame never compares against a stale max.
  always_comb begin
    max_mag_d = max_mag_q;
    max_idx_d = max_idx_q;
    max_i_d   = max_i_q;
    max_q_d   = max_q_q;
    if (state_q == OUT && m_axis_peak_tready) begin
      max_mag_d = '0;
      max_idx_d = '0;
      max_i_d   = '0;
      max_q_d   = '0;
    end else if (mag_valid && (mag_idx == '0 || mag > max_mag_q)) begin
      max_mag_d = mag;
      max_idx_d = mag_idx;
      max_i_d   = mag_i;
      max_q_d   = mag_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_cnt_d  = drain_cnt_q;
    peak_valid_d = peak_valid_q;
    peak_mag_d   = peak_mag_q;
    peak_index_d = peak_index_q;
    peak_i_d     = peak_i_q;
    peak_q_d     = peak_q_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cnt_q == INDEX_BITS'(LENGTH - 1)) begin
            cnt_d       = '0;
            drain_cnt_d = '0;
            state_d     = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d      = OUT;
          peak_valid_d = 1'b1;
          peak_mag_d   = max_mag_q;
          peak_index_d = max_idx_q;
          peak_i_d     = max_i_q;
          peak_q_d     = max_q_q;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      OUT: begin
        if (m_axis_peak_tready) begin
          state_d      = ACCUM;
          peak_valid_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ACCUM;
      cnt_q        <= '0;
      drain_cnt_q  <= '0;
      max_mag_q    <= '0;
      max_idx_q    <= '0;
      max_i_q      <= '0;
      max_q_q      <= '0;
      peak_valid_q <= 1'b0;
      peak_mag_q   <= '0;
      peak_index_q <= '0;
      peak_i_q     <= '0;
      peak_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      max_mag_q    <= max_mag_d;
      max_idx_q    <= max_idx_d;
      max_i_q      <= max_i_d;
      max_q_q      <= max_q_d;
      peak_valid_q <= peak_valid_d;
      peak_mag_q   <= peak_mag_d;
      peak_index_q <= peak_index_d;
      peak_i_q     <= peak_i_d;
      peak_q_q     <= peak_q_d;
    end
  end

  assign s_axis_peak_tvalid = peak_valid_q;
  assign peak_mag           = peak_mag_q;
  assign peak_index         = peak_index_q;
  assign peak_i             = peak_i_q;
  assign peak_q             = peak_q_q;

endmodule

// File: tb/tb_caf_peak_detect.sv
// Directed frames against a frame-level peak model plus literal expectations for caf_peak_detect.
module tb_caf_peak_detect;

  localparam int LEN = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_axis_product_tvalid = 1'b0;
  logic        m_axis_product_tready;
  logic [7:0]  i = '0;
  logic [7:0]  q = '0;
  logic        s_axis_peak_tvalid;
  logic        m_axis_peak_tready = 1'b0;
  logic [16:0] peak_mag;
  logic [2:0]  peak_index;
  logic [7:0]  peak_i;
  logic [7:0]  peak_q;

  int vectors = 0;
  int miscompares = 0;

  caf_peak_detect #(
    .SUM_I_BITS (8),
    .SUM_Q_BITS (8),
    .LENGTH     (LEN),
    .INDEX_BITS (3)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .s_axis_product_tvalid (s_axis_product_tvalid),
    .m_axis_product_tready (m_axis_product_tready),
    .i                     (i),
    .q                     (q),
    .s_axis_peak_tvalid    (s_axis_peak_tvalid),
    .m_axis_peak_tready    (m_axis_peak_tready),
    .peak_mag              (peak_mag),
    .peak_index            (peak_index),
    .peak_i                (peak_i),
    .peak_q                (peak_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: collect accepted samples, pick the first largest i^2+q^2 once LEN are in.
  int         cyc = 0;
  bit         pend = 1'b0;
  int         done_cyc = 0;
  int         mi[$];
  int         mq[$];
  logic [16:0] exp_mag;
  logic [2:0]  exp_idx;
  logic [7:0]  exp_i;
  logic [7:0]  exp_q;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    int best, m;
    cyc = cyc + 1;
    if (reset) begin
      pend = 1'b0;
      mi.delete();
      mq.delete();
    end else if (pend) begin
      if (cyc >= done_cyc + 4 && m_axis_peak_tready) pend = 1'b0;
    end else if (s_axis_product_tvalid) begin
      mi.push_back(int'($signed(i)));
      mq.push_back(int'($signed(q)));
      if (mi.size() == LEN) begin
        best = -1;
        for (int k = 0; k < LEN; k++) begin
          m = mi[k] * mi[k] + mq[k] * mq[k];
          if (m > best) begin
            best    = m;
            exp_mag = 17'(m);
            exp_idx = 3'(k);
            exp_i   = 8'(mi[k]);
            exp_q   = 8'(mq[k]);
          end
        end
        pend     = 1'b1;
        done_cyc = cyc;
        mi.delete();
        mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    bit exp_tv;
    if (chk_en) begin
      exp_tv = pend && (cyc >= done_cyc + 3);
      checkOutput("peak_tvalid", s_axis_peak_tvalid, exp_tv);
      checkOutput("product_tready", m_axis_product_tready, !pend && !reset);
      if (exp_tv) begin
        checkOutput("model peak_mag", peak_mag, exp_mag);
        checkOutput("model peak_index", peak_index, exp_idx);
        checkOutput("model peak_i", peak_i, exp_i);
        checkOutput("model peak_q", peak_q, exp_q);
      end
    end
  end

  int vi[LEN];
  int vq[LEN];
  int last_edge = 0;

  task automatic applyStimulus(input int count, input bit sparse);
    for (int k = 0; k < count; k++) begin
      i = 8'(vi[k]);
      q = 8'(vq[k]);
      s_axis_product_tvalid = 1'b1;
      @(posedge clk);
      #1;
      last_edge = cyc;
      if (sparse) begin
        s_axis_product_tvalid = 1'b0;
        i = 8'h7f;
        q = 8'h7f;
        @(posedge clk);
        #1;
      end
    end
    s_axis_product_tvalid = 1'b0;
  endtask

  task automatic waitResult(input logic [16:0] mag, input logic [2:0] idx,
                            input logic [7:0] pi, input logic [7:0] pq);
    int n;
    n = 0;
    while (!s_axis_peak_tvalid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("result arrives", s_axis_peak_tvalid, 1'b1);
    checkOutput("latency", 64'(cyc - last_edge), 64'd3);
    checkOutput("peak_mag", peak_mag, mag);
    checkOutput("peak_index", peak_index, idx);
    checkOutput("peak_i", peak_i, pi);
    checkOutput("peak_q", peak_q, pq);
  endtask

  task automatic handshake(input int hold);
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    m_axis_peak_tready = 1'b1;
    @(posedge clk);
    #1;
    m_axis_peak_tready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset tvalid", s_axis_peak_tvalid, 1'b0);
    checkOutput("reset tready", m_axis_product_tready, 1'b0);
    checkOutput("reset peak_mag", peak_mag, 17'd0);
    checkOutput("reset peak_index", peak_index, 3'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic frame");
    vi = '{1, 3, 0, 2, -7, 1, 0, 5};
    vq = '{0, 4, -7, 2, 0, 1, 0, 5};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd50, 3'd7, 8'h05, 8'h05);
    handshake(0);

    $display("[TB] tie frame");
    vi = '{1, 2, 0, 1, 7, 3, 0, -4};
    vq = '{0, 0, -7, 1, 0, 3, 0, 4};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd49, 3'd2, 8'h00, 8'hf9);
    handshake(0);

    $display("[TB] extreme frame with backpressure");
    vi = '{-128, 0, 0, 0, 0, 0, 0, 0};
    vq = '{-128, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd32768, 3'd0, 8'h80, 8'h80);
    handshake(10);
    checkOutput("peak_mag held", peak_mag, 17'd32768);

    $display("[TB] clean frame after backpressure");
    vi = '{0, 1, 0, 1, 2, 0, 1, 0};
    vq = '{1, 0, 2, 1, 1, 0, -1, 0};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd5, 3'd4, 8'h02, 8'h01);
    handshake(2);

    $display("[TB] sparse frame");
    vi = '{1, 3, 0, 2, -7, 1, 0, 5};
    vq = '{0, 4, -7, 2, 0, 1, 0, 5};
    applyStimulus(LEN, 1'b1);
    waitResult(17'd50, 3'd7, 8'h05, 8'h05);
    handshake(0);

    $display("[TB] aborted frame then fresh frame");
    vi = '{100, 100, 100, 100, 100, 0, 0, 0};
    vq = '{100, 100, 100, 100, 100, 0, 0, 0};
    applyStimulus(5, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no result after abort", s_axis_peak_tvalid, 1'b0);
    vi = '{3, 1, 0, 2, -1, 4, 0, 1};
    vq = '{-3, 2, 0, 2, 0, 1, 3, 1};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd18, 3'd0, 8'h03, 8'hfd);
    handshake(0);

    $display("[TB] all-zero frame");
    vi = '{0, 0, 0, 0, 0, 0, 0, 0};
    vq = '{0, 0, 0, 0, 0, 0, 0, 0};
    applyStimulus(LEN, 1'b0);
    waitResult(17'd0, 3'd0, 8'h00, 8'h00);
    handshake(0);

    repeat (4) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/caf_peak_detect.md
Name: caf_peak_detect

Overview:
Consumes the complex product stream (i, q) produced by dot_prod_pip and computes |p|^2 = i^2 + q^2 for each sample. Tracks the running maximum over a frame of LENGTH accepted samples, then presents the peak magnitude, its sample index and its raw i/q on a held-valid output handshake. This is the first reduction stage of the CAF search, sitting directly downstream of dot_prod_pip.

Parameters:
SUM_I_BITS, 16, width of signed input i (matches dot_prod_pip sum_i_size)
SUM_Q_BITS, 16, width of signed input q (matches dot_prod_pip sum_q_size)
LENGTH, 64, accepted samples per search frame; must be >= 1
INDEX_BITS, 6, index width; must satisfy 2^INDEX_BITS >= LENGTH

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
s_axis_product_tvalid  in  1  upstream product valid
m_axis_product_tready  out  1  ready to accept a product sample
i  in  SUM_I_BITS  signed in-phase product
q  in  SUM_Q_BITS  signed quadrature product
s_axis_peak_tvalid  out  1  peak result valid
m_axis_peak_tready  in  1  downstream accepts the result
peak_mag  out  MAG_BITS  peak |p|^2, unsigned
peak_index  out  INDEX_BITS  frame index (0..LENGTH-1) of the peak
peak_i  out  SUM_I_BITS  i of the peak sample
peak_q  out  SUM_Q_BITS  q of the peak sample

Behaviour:
- Clock clk; reset is synchronous, active-high; the polarity and synchronicity are fixed.
- MAG_BITS = 2*max(SUM_I_BITS,SUM_Q_BITS)+1. Squares use signed multiply, producing a non-negative result. The sum is computed without truncation, so -2^(W-1) squared must be exact.
- Accept = s_axis_product_tvalid & m_axis_product_tready.
- m_axis_product_tready = (state==ACCUM) & ~reset, combinational.
- States:
  - ACCUM: accepting samples; sample counter cnt increments per accept. An accept with cnt==LENGTH-1 -> DRAIN, and cnt returns to 0.
  - DRAIN: no accepts; waits 2 cycles for the pipeline to empty, then -> OUT.
  - OUT: s_axis_peak_tvalid=1. The result is stable until m_axis_peak_tready=1 is seen on a rising edge, then -> ACCUM next cycle with the running max cleared.
- Pipeline is 3 stages, each advancing only on accept and bubble-tagged with a valid bit:
  - S1: register i*i, q*q, i, q, idx.
  - S2: register mag = sum, i, q, idx.
  - S3: compare-and-update against the running max.
  - The running max clears at frame start. The first sample of a frame always loads.
  - Update only on strictly greater, so ties keep the earliest index.
- Latency: last sample accepted at edge N -> outputs registered at edge N+3; s_axis_peak_tvalid is high from then until handshake.
- Pipeline never stalls internally. Upstream backpressure comes only from tready=0 in DRAIN/OUT. tvalid gaps during ACCUM insert bubbles and do not advance cnt.
- Reset values: state=ACCUM, cnt=0, all pipeline valid bits 0, s_axis_peak_tvalid=0, peak_mag/peak_index/peak_i/peak_q=0.
- Reset mid-frame or mid-OUT discards all partial state and any pending result; no result is emitted for that frame.
- All-zero frame: peak_mag=0, peak_index=0.
- LENGTH=1: every sample is a full frame.
- Result outputs only change when entering OUT.

Decomposition:
- Package caf_pkg: state enum (ACCUM, DRAIN, OUT), function mag_bits(wi,wq), function clog2 for INDEX_BITS checks.
- Sub-module cmag_sq: two-stage registered complex magnitude-squared with valid and sideband (i, q, idx) pass-through.
- caf_peak_detect holds the FSM, counter and compare stage.

Test Plan:
- LENGTH=8, W=8, continuous tvalid; i,q = (1,0),(3,4),(0,-7),(2,2),(-7,0),(1,1),(0,0),(5,5) -> peak_mag=50, peak_index=7, peak_i=5, peak_q=5. tvalid rises 3 cycles after the 8th accept.
- Tie: mags 49 at index 2 and index 4, nothing larger -> peak_index=2, peak_i=0, peak_q=-7.
- Extreme: i=-128, q=-128 at index 0, rest 0 -> peak_mag=32768 (exact, no overflow), peak_index=0.
- Backpressure: hold m_axis_peak_tready=0 for 10 cycles in OUT -> outputs stable, m_axis_product_tready=0 throughout. After handshake, the next frame starts clean with its peak from the new data only.
- Sparse input: tvalid toggled 1-0-1-... over the frame -> same result as continuous input; cnt advances only on accept.
- Reset asserted after the 5th accept, then a full new frame -> no result for the aborted frame; the new frame's peak is correct and the index starts at 0.
